// File: rtl/ram_access_sched.sv
// Round-robin burst scheduler sharing one single-port RAM between the loader (writes)
// and the divider core (reads); sequences addresses from a latched base/length.
module ram_access_sched #(
  parameter int unsigned RAM_ADDR_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      asyn_reset,
  input  logic                      req0,
  input  logic [RAM_ADDR_WIDTH+1:0] base0,
  input  logic [RAM_ADDR_WIDTH+1:0] len0,
  input  logic                      req1,
  input  logic [RAM_ADDR_WIDTH+1:0] base1,
  input  logic [RAM_ADDR_WIDTH+1:0] len1,
  input  logic                      stall,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [RAM_ADDR_WIDTH+1:0] ram_addr,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic                      busy
);

  localparam int unsigned AW = RAM_ADDR_WIDTH + 2;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW-1:0]   len_q, len_d;
  logic [AW-1:0]   offset_q, offset_d;
  logic            last_q, last_d;
  logic            pick;

  // last_q holds the most recently served requester; reset value 1 lets requester 0 win the first tie
  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      base_q   <= base_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    base_d   = base_q;
    len_d    = len_q;
    offset_d = offset_q;
    last_d   = last_q;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          pick     = (req0 && req1) ? ~last_q : req1;
          gnt_d    = pick ? 2'b10 : 2'b01;
          base_d   = pick ? base1 : base0;
          len_d    = pick ? len1 : len0;
          offset_d = '0;
          state_d  = (len_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          offset_d = offset_q + ONE;
          if (offset_q == len_q - ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        last_d  = gnt_q[1];
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en   = (state_q == RUN) && !stall;
    ram_we   = ram_en && gnt_q[0];
    ram_addr = (state_q == RUN) ? (base_q + offset_q) : '0;
    done     = (state_q == DONE) ? gnt_q : '0;
    busy     = (state_q != IDLE);
    gnt      = gnt_q;
  end

endmodule

// File: tb/tb_ram_access_sched.sv
// Self-checking bench for ram_access_sched: directed vector table, hand-written
// corner sequences and randomized traffic against a burst-level reference model.
module tb_ram_access_sched;

  logic       clk;
  logic       asyn_reset;
  logic       req0, req1, stall;
  logic [8:0] base0, len0, base1, len1;
  logic       ram_en, ram_we, busy;
  logic [8:0] ram_addr;
  logic [1:0] gnt, done;

  int n_err;
  int n_chk;

  ram_access_sched #(.RAM_ADDR_WIDTH(7)) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .req0      (req0),
    .base0     (base0),
    .len0      (len0),
    .req1      (req1),
    .base1     (base1),
    .len1      (len1),
    .stall     (stall),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r0;
    logic [8:0] b0;
    logic [8:0] l0;
    logic       r1;
    logic [8:0] b1;
    logic [8:0] l1;
    logic       st;
    logic       en;
    logic       we;
    logic [8:0] addr;
    logic [1:0] g;
    logic [1:0] d;
    logic       bz;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(int r0, int b0, int l0, int r1, int b1, int l1, int st,
                              int en, int we, int addr, int g, int d, int bz);
    vec_t v;
    v.r0 = (r0 != 0);  v.b0 = 9'(b0);  v.l0 = 9'(l0);
    v.r1 = (r1 != 0);  v.b1 = 9'(b1);  v.l1 = 9'(l1);
    v.st = (st != 0);
    v.en = (en != 0);  v.we = (we != 0);  v.addr = 9'(addr);
    v.g  = 2'(g);      v.d  = 2'(d);      v.bz = (bz != 0);
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; stall = 1'b0;
    base0 = '0; len0 = '0; base1 = '0; len1 = '0;
  endtask

  task automatic do_reset();
    asyn_reset = 1'b1;
    drive_idle();
    #2;
    @(posedge clk);
    #3;
    asyn_reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // burst-level reference model
  int m_owner, m_left, m_addr, m_tie;

  task automatic model_update(input int r0, input int b0, input int l0,
                              input int r1, input int b1, input int l1, input int st);
    if (m_owner < 0) begin
      if (r0 != 0 || r1 != 0) begin
        m_owner = (r0 != 0 && r1 != 0) ? m_tie : ((r0 != 0) ? 0 : 1);
        m_addr  = (m_owner == 0) ? b0 : b1;
        m_left  = (m_owner == 0) ? l0 : l1;
      end
    end else if (m_left > 0) begin
      if (st == 0) begin
        m_addr = (m_addr + 1) % 512;
        m_left--;
      end
    end else begin
      m_tie   = 1 - m_owner;
      m_owner = -1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_err = 0;
    n_chk = 0;
    asyn_reset = 1'b1;
    drive_idle();
    #3;
    chk("reset ram_en",   int'(ram_en),   0);
    chk("reset ram_we",   int'(ram_we),   0);
    chk("reset ram_addr", int'(ram_addr), 0);
    chk("reset gnt",      int'(gnt),      0);
    chk("reset done",     int'(done),     0);
    chk("reset busy",     int'(busy),     0);

    // inputs applied in row i, outputs checked in the same cycle
    //            r0 b0     l0 r1 b1     l1 st | en we addr    g  d  bz
    tbl[0]  = mk(1, 'h010, 4, 0, 0,     0, 0,   0, 0, 0,     0, 0, 0);
    tbl[1]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 1, 'h010, 1, 0, 1);
    tbl[2]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 1, 'h011, 1, 0, 1);
    tbl[3]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 1, 'h012, 1, 0, 1);
    tbl[4]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 1, 'h013, 1, 0, 1);
    tbl[5]  = mk(0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     1, 1, 1);
    tbl[6]  = mk(0, 0,     0, 1, 'h020, 3, 0,   0, 0, 0,     0, 0, 0);
    tbl[7]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 0, 'h020, 2, 0, 1);
    tbl[8]  = mk(0, 0,     0, 0, 0,     0, 1,   0, 0, 'h021, 2, 0, 1);
    tbl[9]  = mk(0, 0,     0, 0, 0,     0, 0,   1, 0, 'h021, 2, 0, 1);
    tbl[10] = mk(0, 0,     0, 0, 0,     0, 0,   1, 0, 'h022, 2, 0, 1);
    tbl[11] = mk(0, 0,     0, 0, 0,     0, 1,   0, 0, 0,     2, 2, 1);
    tbl[12] = mk(0, 0,     0, 1, 'h033, 0, 1,   0, 0, 0,     0, 0, 0);
    tbl[13] = mk(0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     2, 2, 1);
    tbl[14] = mk(0, 0,     0, 0, 0,     0, 0,   0, 0, 0,     0, 0, 0);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      req0 = tbl[i].r0; base0 = tbl[i].b0; len0 = tbl[i].l0;
      req1 = tbl[i].r1; base1 = tbl[i].b1; len1 = tbl[i].l1;
      stall = tbl[i].st;
      #1;
      chk($sformatf("row%0d ram_en", i),   int'(ram_en),   int'(tbl[i].en));
      chk($sformatf("row%0d ram_we", i),   int'(ram_we),   int'(tbl[i].we));
      chk($sformatf("row%0d ram_addr", i), int'(ram_addr), int'(tbl[i].addr));
      chk($sformatf("row%0d gnt", i),      int'(gnt),      int'(tbl[i].g));
      chk($sformatf("row%0d done", i),     int'(done),     int'(tbl[i].d));
      chk($sformatf("row%0d busy", i),     int'(busy),     int'(tbl[i].bz));
      step();
    end

    // tie arbitration from reset: alternation 0,1,0,1
    do_reset();
    req0 = 1'b1; base0 = 9'h100; len0 = 9'd2;
    req1 = 1'b1; base1 = 9'h180; len1 = 9'd2;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (gnt == 2'b00 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("tie%0d grant latency", k), n, 1);
      chk($sformatf("tie%0d gnt", k),      int'(gnt),      (k % 2 == 0) ? 1 : 2);
      chk($sformatf("tie%0d ram_we", k),   int'(ram_we),   (k % 2 == 0) ? 1 : 0);
      chk($sformatf("tie%0d ram_addr", k), int'(ram_addr), (k % 2 == 0) ? 'h100 : 'h180);
      n = 0;
      while (gnt != 2'b00 && n < 20) begin
        step();
        n++;
      end
      chk($sformatf("tie%0d burst+done cycles", k), n, 3);
    end

    // address wrap-around
    do_reset();
    req0 = 1'b1; base0 = 9'h1FE; len0 = 9'd4;
    step();
    req0 = 1'b0;
    #1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("wrap%0d ram_addr", j), int'(ram_addr), (9'h1FE + j) % 512);
      chk($sformatf("wrap%0d ram_en", j),   int'(ram_en),   1);
      step();
      #1;
    end
    chk("wrap done",   int'(done),   1);
    chk("wrap ram_en", int'(ram_en), 0);
    step();
    chk("wrap busy after", int'(busy), 0);

    // asynchronous reset during the 3rd access of a len=8 burst
    do_reset();
    req0 = 1'b1; base0 = 9'h040; len0 = 9'd8;
    step();
    req0 = 1'b0;
    step();
    step();
    chk("rstmid 3rd addr", int'(ram_addr), 'h042);
    chk("rstmid 3rd en",   int'(ram_en),   1);
    req1 = 1'b1; base1 = 9'h055; len1 = 9'd1;
    #2;
    asyn_reset = 1'b1;
    #1;
    chk("rstmid ram_en",   int'(ram_en),   0);
    chk("rstmid ram_we",   int'(ram_we),   0);
    chk("rstmid ram_addr", int'(ram_addr), 0);
    chk("rstmid gnt",      int'(gnt),      0);
    chk("rstmid busy",     int'(busy),     0);
    chk("rstmid done",     int'(done),     0);
    step();
    chk("rstmid held done", int'(done), 0);
    chk("rstmid held busy", int'(busy), 0);
    #2;
    asyn_reset = 1'b0;
    step();
    chk("post-rst gnt",      int'(gnt),      2);
    chk("post-rst ram_en",   int'(ram_en),   1);
    chk("post-rst ram_we",   int'(ram_we),   0);
    chk("post-rst ram_addr", int'(ram_addr), 'h055);
    req1 = 1'b0;
    step();
    chk("post-rst done", int'(done), 2);

    // randomized traffic against the reference model
    do_reset();
    m_owner = -1; m_left = 0; m_addr = 0; m_tie = 0;
    for (int c = 0; c < 3000; c++) begin
      int r0, b0, l0, r1, b1, l1, st;
      int e_en, e_addr, e_gnt, e_done, run;
      r0 = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r1 = ($urandom_range(0, 2) == 0) ? 1 : 0;
      b0 = int'($urandom_range(0, 511));
      b1 = int'($urandom_range(0, 511));
      l0 = int'($urandom_range(0, 5));
      l1 = int'($urandom_range(0, 5));
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      req0 = (r0 != 0); base0 = 9'(b0); len0 = 9'(l0);
      req1 = (r1 != 0); base1 = 9'(b1); len1 = 9'(l1);
      stall = (st != 0);
      #1;
      run    = (m_owner >= 0 && m_left > 0) ? 1 : 0;
      e_en   = (run != 0 && st == 0) ? 1 : 0;
      e_addr = (run != 0) ? m_addr : 0;
      e_gnt  = (m_owner < 0) ? 0 : ((m_owner == 0) ? 1 : 2);
      e_done = (m_owner >= 0 && m_left == 0) ? e_gnt : 0;
      chk($sformatf("rnd%0d ram_en", c),   int'(ram_en),   e_en);
      chk($sformatf("rnd%0d ram_we", c),   int'(ram_we),   (e_en != 0 && m_owner == 0) ? 1 : 0);
      chk($sformatf("rnd%0d ram_addr", c), int'(ram_addr), e_addr);
      chk($sformatf("rnd%0d gnt", c),      int'(gnt),      e_gnt);
      chk($sformatf("rnd%0d done", c),     int'(done),     e_done);
      chk($sformatf("rnd%0d busy", c),     int'(busy),     (m_owner >= 0) ? 1 : 0);
      @(posedge clk);
      model_update(r0, b0, l0, r1, b1, l1, st);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
